// File: rtl/pum_pkg.sv
// rtl/pum_pkg.sv - shared owner id, read-tag type and arbitration defaults
package pum_pkg;

  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ACC  = 1'b1
  } own_e;

  typedef struct packed {
    logic valid;
    logic rd;
    own_e id;
  } tag_t;

endpackage

// File: rtl/pum_arb_prio.sv
// rtl/pum_arb_prio.sv - fixed-priority grant with per-requester starvation override
module pum_arb_prio
  import pum_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic h_req,
  input  logic a_req,
  input  logic cfg_acc_prio,
  output logic h_gnt,
  output logic a_gnt
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_h_starve;
  logic [CNT_W-1:0] r_a_starve;
  logic             w_h_starved;
  logic             w_a_starved;

  assign w_h_starved = (r_h_starve == CNT_MAX);
  assign w_a_starved = (r_a_starve == CNT_MAX);

  // Only the non-priority side can be starved, so only its counter overrides.
  always_comb begin
    h_gnt = 1'b0;
    a_gnt = 1'b0;
    if (h_req && a_req) begin
      if (cfg_acc_prio) begin
        if (w_h_starved) h_gnt = 1'b1;
        else             a_gnt = 1'b1;
      end else begin
        if (w_a_starved) a_gnt = 1'b1;
        else             h_gnt = 1'b1;
      end
    end else begin
      h_gnt = h_req;
      a_gnt = a_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_starve <= '0;
      r_a_starve <= '0;
    end else begin
      if (!h_req || h_gnt)        r_h_starve <= '0;
      else if (!w_h_starved)      r_h_starve <= r_h_starve + 1'b1;

      if (!a_req || a_gnt)        r_a_starve <= '0;
      else if (!w_a_starved)      r_a_starve <= r_a_starve + 1'b1;
    end
  end

endmodule

// File: rtl/pum_mem_arb.sv
// rtl/pum_mem_arb.sv - host/accelerator arbiter for one wide memory port
// Optional grant/conflict statistics counters when PUM_ARB_STATS_EN is defined.
module pum_mem_arb
  import pum_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 1024,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              cfg_acc_prio,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef PUM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_h_cnt,
  output logic [31:0]       stat_a_cnt,
  output logic [31:0]       stat_conf_cnt,
`endif
  output logic              busy
);

  logic              w_h_gnt;
  logic              w_a_gnt;
  logic              w_any_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_h_rvalid;
  logic              w_a_rvalid;

  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic [DATA_W-1:0] r_h_rdata;
  logic [DATA_W-1:0] r_a_rdata;

  pum_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_req        (h_req),
    .a_req        (a_req),
    .cfg_acc_prio (cfg_acc_prio),
    .h_gnt        (w_h_gnt),
    .a_gnt        (w_a_gnt)
  );

  assign w_any_gnt   = w_h_gnt | w_a_gnt;
  assign w_sel_we    = w_a_gnt ? a_we    : h_we;
  assign w_sel_addr  = w_a_gnt ? a_addr  : h_addr;
  assign w_sel_wdata = w_a_gnt ? a_wdata : h_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_rd <= w_any_gnt & ~w_sel_we;
      r_mem_wr <= w_any_gnt & w_sel_we;
      if (w_any_gnt) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  // Stage 1 lines up with the command, stage 2 with the returning mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1 <= tag_t'{valid: w_any_gnt,
                       rd:    w_any_gnt & ~w_sel_we,
                       id:    (w_a_gnt ? OWN_ACC : OWN_HOST)};
      r_tag2 <= r_tag1;
    end
  end

  assign w_h_rvalid = r_tag2.valid & r_tag2.rd & (r_tag2.id == OWN_HOST);
  assign w_a_rvalid = r_tag2.valid & r_tag2.rd & (r_tag2.id == OWN_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_rdata <= '0;
      r_a_rdata <= '0;
    end else begin
      if (w_h_rvalid) r_h_rdata <= mem_rdata;
      if (w_a_rvalid) r_a_rdata <= mem_rdata;
    end
  end

`ifdef PUM_ARB_STATS_EN
  logic [31:0] r_stat_h;
  logic [31:0] r_stat_a;
  logic [31:0] r_stat_conf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_h    <= '0;
      r_stat_a    <= '0;
      r_stat_conf <= '0;
    end else if (stat_clr) begin
      r_stat_h    <= '0;
      r_stat_a    <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_h_gnt)         r_stat_h    <= r_stat_h + 32'd1;
      if (w_a_gnt)         r_stat_a    <= r_stat_a + 32'd1;
      if (h_req && a_req)  r_stat_conf <= r_stat_conf + 32'd1;
    end
  end

  assign stat_h_cnt    = r_stat_h;
  assign stat_a_cnt    = r_stat_a;
  assign stat_conf_cnt = r_stat_conf;
`endif

  assign h_gnt     = w_h_gnt;
  assign a_gnt     = w_a_gnt;
  assign h_rvalid  = w_h_rvalid;
  assign a_rvalid  = w_a_rvalid;
  // Read data is live while rvalid is high and otherwise shows the last returned word.
  assign h_rdata   = w_h_rvalid ? mem_rdata : r_h_rdata;
  assign a_rdata   = w_a_rvalid ? mem_rdata : r_a_rdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_tag1.valid | r_tag2.valid;

endmodule

// File: tb/tb_pum_mem_arb.sv
// tb/tb_pum_mem_arb.sv - directed bench with a cycle-level reference model of the arbiter
module tb_pum_mem_arb;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 1024;
  localparam int STARVE_MAX = 8;

  logic              clk;
  logic              rst_n;
  logic              h_req, h_we, a_req, a_we, cfg_acc_prio;
  logic [ADDR_W-1:0] h_addr, a_addr;
  logic [DATA_W-1:0] h_wdata, a_wdata;
  logic              h_gnt, h_rvalid, a_gnt, a_rvalid;
  logic [DATA_W-1:0] h_rdata, a_rdata;
  logic              mem_rd, mem_wr, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef PUM_ARB_STATS_EN
  logic              stat_clr;
  logic [31:0]       stat_h_cnt, stat_a_cnt, stat_conf_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pum_mem_arb #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_req        (h_req),
    .h_we         (h_we),
    .h_addr       (h_addr),
    .h_wdata      (h_wdata),
    .h_gnt        (h_gnt),
    .h_rvalid     (h_rvalid),
    .h_rdata      (h_rdata),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .cfg_acc_prio (cfg_acc_prio),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
`ifdef PUM_ARB_STATS_EN
    .stat_clr      (stat_clr),
    .stat_h_cnt    (stat_h_cnt),
    .stat_a_cnt    (stat_a_cnt),
    .stat_conf_cnt (stat_conf_cnt),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  // Memory environment: one-cycle read latency.
  logic [DATA_W-1:0] env_mem [int];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_wr) env_mem[int'(mem_addr)] = mem_wdata;
    if (mem_rd) mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : '0;
  end

  // Reference model: expected transactions travel through a two-slot delay line.
  typedef struct {
    bit                valid;
    bit                rd;
    bit                acc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t              m_s1, m_s2, m_new;
  exp_t              m_empty;
  int                m_h_loss, m_a_loss;
  bit                m_eh, m_ea;
  logic [DATA_W-1:0] m_mem [int];
  logic [DATA_W-1:0] m_hold_h, m_hold_a;

  function automatic logic [DATA_W-1:0] m_lookup(input int a);
    if (m_mem.exists(a)) return m_mem[a];
    return '0;
  endfunction

  initial begin
    m_empty  = '{valid: 0, rd: 0, acc: 0, addr: '0, wdata: '0, rdata: '0};
    m_s1     = m_empty;
    m_s2     = m_empty;
    m_h_loss = 0;
    m_a_loss = 0;
    m_hold_h = '0;
    m_hold_a = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst h_gnt", h_gnt, 0);
      chk("rst a_gnt", a_gnt, 0);
      chk("rst mem_rd", mem_rd, 0);
      chk("rst mem_wr", mem_wr, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst h_rvalid", h_rvalid, 0);
      chk("rst a_rvalid", a_rvalid, 0);
      chk("rst h_rdata", h_rdata, 0);
      chk("rst a_rdata", a_rdata, 0);
      chk("rst busy", busy, 0);
      m_s1 = m_empty;
      m_s2 = m_empty;
      m_h_loss = 0;
      m_a_loss = 0;
      m_hold_h = '0;
      m_hold_a = '0;
    end else begin
      chk("m mem_rd", mem_rd, m_s1.valid && m_s1.rd);
      chk("m mem_wr", mem_wr, m_s1.valid && !m_s1.rd);
      if (m_s1.valid) chk("m mem_addr", mem_addr, m_s1.addr);
      if (m_s1.valid && !m_s1.rd) chk("m mem_wdata", mem_wdata, m_s1.wdata);
      chk("m h_rvalid", h_rvalid, m_s2.valid && m_s2.rd && !m_s2.acc);
      chk("m a_rvalid", a_rvalid, m_s2.valid && m_s2.rd && m_s2.acc);
      if (m_s2.valid && m_s2.rd && !m_s2.acc) m_hold_h = m_s2.rdata;
      if (m_s2.valid && m_s2.rd && m_s2.acc)  m_hold_a = m_s2.rdata;
      chk("m h_rdata", h_rdata, m_hold_h);
      chk("m a_rdata", a_rdata, m_hold_a);
      chk("m busy", busy, m_s1.valid || m_s2.valid);

      m_eh = 0;
      m_ea = 0;
      if (h_req && a_req) begin
        if (cfg_acc_prio) begin
          if (m_h_loss >= STARVE_MAX) m_eh = 1; else m_ea = 1;
        end else begin
          if (m_a_loss >= STARVE_MAX) m_ea = 1; else m_eh = 1;
        end
      end else begin
        m_eh = h_req;
        m_ea = a_req;
      end
      chk("m h_gnt", h_gnt, m_eh);
      chk("m a_gnt", a_gnt, m_ea);

      m_h_loss = (h_req && !m_eh) ? ((m_h_loss < STARVE_MAX) ? m_h_loss + 1 : m_h_loss) : 0;
      m_a_loss = (a_req && !m_ea) ? ((m_a_loss < STARVE_MAX) ? m_a_loss + 1 : m_a_loss) : 0;

      m_new = m_empty;
      if (m_eh || m_ea) begin
        m_new.valid = 1;
        m_new.acc   = m_ea;
        m_new.rd    = m_ea ? !a_we : !h_we;
        m_new.addr  = m_ea ? a_addr : h_addr;
        m_new.wdata = m_ea ? a_wdata : h_wdata;
        if (m_new.rd) m_new.rdata = m_lookup(int'(m_new.addr));
        else          m_mem[int'(m_new.addr)] = m_new.wdata;
      end
      m_s2 = m_s1;
      m_s1 = m_new;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_h(input bit req, input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    h_req = req; h_we = we; h_addr = addr; h_wdata = d;
  endtask

  task automatic set_a(input bit req, input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    a_req = req; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  logic [DATA_W-1:0] d_a5, d_1;
  int hcnt, acnt, hfirst, hlast, busy_low, hrv, arv;

  initial begin
    d_a5 = {16{64'hA5A5_A5A5_A5A5_A5A5}};
    d_1  = {16{64'h0123_4567_89AB_CDEF}};
    rst_n = 1'b0;
    cfg_acc_prio = 1'b0;
    set_h(0, 0, '0, '0);
    set_a(0, 0, '0, '0);
`ifdef PUM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset mem_wr", mem_wr, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Lone host write.
    set_h(1, 1, 14'h010, d_a5);
    @(negedge clk);
    chk("wr h_gnt", h_gnt, 1);
    chk("wr a_gnt", a_gnt, 0);
    tick();
    set_h(0, 0, '0, '0);
    @(negedge clk);
    chk("wr mem_wr", mem_wr, 1);
    chk("wr mem_rd", mem_rd, 0);
    chk("wr mem_addr", mem_addr, 14'h010);
    chk("wr mem_wdata", mem_wdata, d_a5);
    tick();
    @(negedge clk);
    chk("wr h_rvalid", h_rvalid, 0);
    chk("wr a_rvalid", a_rvalid, 0);

    // Accelerator write then back-to-back read of the top address.
    tick();
    set_a(1, 1, 14'h3FFF, d_1);
    @(negedge clk);
    chk("rd0 a_gnt", a_gnt, 1);
    tick();
    set_a(1, 0, 14'h3FFF, '0);
    @(negedge clk);
    chk("rd1 a_gnt", a_gnt, 1);
    chk("rd1 mem_wr", mem_wr, 1);
    tick();
    set_a(0, 0, '0, '0);
    @(negedge clk);
    chk("rd2 mem_rd", mem_rd, 1);
    chk("rd2 mem_addr", mem_addr, 14'h3FFF);
    tick();
    @(negedge clk);
    chk("rd3 a_rvalid", a_rvalid, 1);
    chk("rd3 a_rdata", a_rdata, d_1);
    chk("rd3 h_rvalid", h_rvalid, 0);

    // Continuous conflict with accelerator priority: 8 acc grants, then 1 host grant.
    tick();
    cfg_acc_prio = 1'b1;
    set_h(1, 0, 14'h010, '0);
    set_a(1, 0, 14'h3FFF, '0);
    hcnt = 0; acnt = 0; hfirst = -1; hlast = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (h_gnt) begin
        hcnt++;
        if (hfirst < 0) hfirst = i;
        hlast = i;
      end
      if (a_gnt) acnt++;
      tick();
    end
    chk("starve host grants", 32'(hcnt), 2);
    chk("starve acc grants", 32'(acnt), 16);
    chk("starve first host", 32'(hfirst), 8);
    chk("starve second host", 32'(hlast), 17);
    cfg_acc_prio = 1'b0;
    repeat (4) tick();
    set_h(0, 0, '0, '0);
    set_a(0, 0, '0, '0);
    repeat (3) tick();

    // Alternating host/accelerator reads every cycle.
    busy_low = 0; hrv = 0; arv = 0;
    for (int i = 0; i < 8; i++) begin
      set_h((i % 2) == 0, 0, 14'h010, '0);
      set_a((i % 2) == 1, 0, 14'h3FFF, '0);
      @(negedge clk);
      if (i >= 1 && !busy) busy_low++;
      if (h_rvalid) hrv++;
      if (a_rvalid) arv++;
      tick();
    end
    set_h(0, 0, '0, '0);
    set_a(0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (h_rvalid) hrv++;
      if (a_rvalid) arv++;
      tick();
    end
    chk("alt busy gaps", 32'(busy_low), 0);
    chk("alt h_rvalid count", 32'(hrv), 4);
    chk("alt a_rvalid count", 32'(arv), 4);
    repeat (2) tick();

    // Reset during the command cycle of a read.
    set_h(1, 0, 14'h010, '0);
    @(negedge clk);
    chk("rrst h_gnt", h_gnt, 1);
    tick();
    set_h(0, 0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rrst mem_rd", mem_rd, 0);
    chk("rrst busy", busy, 0);
    chk("rrst h_rdata", h_rdata, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    hrv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (h_rvalid || a_rvalid) hrv++;
      tick();
    end
    chk("rrst no rvalid", 32'(hrv), 0);

`ifdef PUM_ARB_STATS_EN
    cfg_acc_prio = 1'b1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    set_h(1, 0, 14'h010, '0);
    set_a(1, 0, 14'h3FFF, '0);
    repeat (5) tick();
    set_h(0, 0, '0, '0);
    set_a(0, 0, '0, '0);
    stat_clr = 1'b1;
    @(negedge clk);
    chk("stat conf", stat_conf_cnt, 5);
    chk("stat grants", stat_h_cnt + stat_a_cnt, 5);
    chk("stat acc", stat_a_cnt, 5);
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    chk("stat conf cleared", stat_conf_cnt, 0);
    chk("stat acc cleared", stat_a_cnt, 0);
    repeat (3) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pum_mem_arb.md
PUM_MEM_ARB -- requirements
Module: pum_mem_arb

Interface
- REQ-001 SHALL have parameter ADDR_W, default 14, the wide-memory row address width.
- REQ-002 SHALL have parameter DATA_W, default 1024, the wide-memory data width.
- REQ-003 SHALL have parameter STARVE_MAX, default 8, the maximum number of consecutive lost arbitrations before forced grant.
- REQ-004 SHALL have port clk, input, 1 bit; clock, rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
- REQ-006 SHALL have ports h_req, h_we (input, 1 bit), h_addr (input, ADDR_W) and h_wdata (input, DATA_W): the host requester command, held stable until granted.
- REQ-007 SHALL have ports h_gnt and h_rvalid (output, 1 bit) and h_rdata (output, DATA_W): the host grant pulse, read-valid pulse and read data.
- REQ-008 SHALL have ports a_req, a_we, a_addr, a_wdata, a_gnt, a_rvalid and a_rdata: the accelerator requester, with the same widths and semantics as the host set.
- REQ-009 SHALL have port cfg_acc_prio, input, 1 bit: 1 = accelerator has fixed priority, 0 = host has fixed priority.
- REQ-010 SHALL have ports mem_rd and mem_wr (output, 1 bit), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the registered memory command.
- REQ-011 SHALL have port mem_rdata, input, DATA_W: memory read data, valid exactly 1 cycle after mem_rd.
- REQ-012 SHALL have port busy, output, 1 bit: high when any command or read is in flight.

Function
- REQ-013 SHALL compute h_gnt and a_gnt combinationally in cycle T; at most one is high; no grant is issued without the corresponding req.
- REQ-014 SHALL drive the winner's command on mem_rd/mem_wr/mem_addr/mem_wdata in cycle T+1 and return read data with xx_rvalid in cycle T+2; all other cycles mem_rd=mem_wr=0.
- REQ-015 SHALL grant a single requester whenever it requests.
- REQ-016 SHALL, on conflict, grant the priority requester per cfg_acc_prio unless the loser's starve counter equals STARVE_MAX, in which case the loser wins.
- REQ-017 SHALL keep the starve counter at 0..STARVE_MAX: +1 per cycle the owner requests and loses, saturating; cleared when the owner is granted or drops req.
- REQ-018 SHALL keep a 2-stage owner-tag pipeline (valid, rd, id) that routes mem_rdata and is the sole source of h_rvalid/a_rvalid.
- REQ-019 SHALL sustain back-to-back grants one per cycle with no bubble; a write in T followed by a read of the same address in T+1 returns the new data (memory ordering).
- REQ-020 SHALL drive h_rdata/a_rdata as mem_rdata when the respective rvalid is high and hold the last value otherwise.
- REQ-021 SHALL take cfg_acc_prio changes effect in the next arbitration cycle; in-flight commands are unaffected.
- REQ-022 SHALL drive busy as (tag stage1 valid | tag stage2 valid).

Reset
- REQ-023 SHALL, on rst_n low, immediately clear mem_rd, mem_wr, mem_addr, mem_wdata, both rvalids, both rdata, the tag pipeline, the starve counters and busy to 0.
- REQ-024 SHALL discard reads in flight at reset with no rvalid; grants remain combinational (0 while no req).

Configuration
- REQ-025 SHALL, when PUM_ARB_STATS_EN is defined, add outputs stat_h_cnt, stat_a_cnt and stat_conf_cnt (32 bit each, wrap-around): host grants, accelerator grants and conflict cycles, cleared by reset and by input stat_clr (1 bit, synchronous).
- REQ-026 SHALL, without PUM_ARB_STATS_EN, have neither those ports nor the counters.

Structure
- REQ-027 SHALL place the owner-id enum (OWN_HOST, OWN_ACC), the tag struct and the default STARVE_MAX in shared package pum_pkg.
- REQ-028 SHALL place the grant decision plus starve counters in sub-module pum_arb_prio; the command register, tag pipeline and stats SHALL stay in pum_mem_arb.

Verification
- REQ-029 SHALL verify: h_req write addr 0x010, data 0xA5.. alone -> h_gnt in T, mem_wr=1 with mem_addr=0x010 in T+1, no rvalid.
- REQ-030 SHALL verify: a_req read addr 0x3FFF after a write there -> a_gnt in T, mem_rd in T+1, a_rvalid with the written data in T+2, h_rvalid=0.
- REQ-031 SHALL verify: both requesting continuously, cfg_acc_prio=1, STARVE_MAX=8 -> 8 accelerator grants, then 1 host grant, repeating.
- REQ-032 SHALL verify: alternating host read/accelerator read every cycle -> rvalid routing matches the id each cycle, busy held high, no bubble.
- REQ-033 SHALL verify: rst_n asserted in T+1 of a read -> no rvalid ever issued for it, and all outputs are 0 during reset.
- REQ-034 SHALL verify, with PUM_ARB_STATS_EN: 5 conflict cycles then stat_clr -> stat_conf_cnt=5, then 0 the cycle after stat_clr.
